uart_rx_os: RTL and testbench

Parametrised, oversampling UART receiver that supersedes the fixed 8-bit, 2-clocks-per-bit receiver. It runs on one system clock and is qualified by an external `sample_tick` enable at OVERSAMPLE × baud. It adds an input synchroniser, majority-vote mid-bit sampling, configurable data/parity/stop format, error flags and a valid/ready output handshake. It sits between the Basys3 RX pin and the byte consumer (FIFO or command decoder). The companion baud generator supplies `sample_tick`.

---
 rtl/uart_rx_os.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: two-flop synchroniser, 3-sample majority vote at mid-bit,
// configurable data/parity/stop format, error flags and a valid/ready output register.
module uart_rx_os #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF      = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_LAST      = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [2:0]           smp_q, smp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic rx_s;
  logic vote;
  logic at_last;
  logic commit;

  assign rx_s = sync_q[1];
  // Vote over the two previously stored samples plus the one taken on this tick.
  assign vote = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s) | (smp_q[0] & rx_s);
  // The counter is restarted at the start-bit centre, so every later wrap lands mid-bit.
  assign at_last = (cnt_q == CNT_LAST);
  assign commit  = sample_tick && (state_q == ST_STOP) && at_last && (idx_q == IDX_STOP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sync_q     <= 2'b11;
      smp_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      smp_q      <= smp_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sample_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s && armed_q) state_d = ST_START;
        end
        ST_START: begin
          if (cnt_q == CNT_HALF) state_d = vote ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (at_last && (idx_q == IDX_DATA_LAST)) state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (at_last) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (at_last && (idx_q == IDX_STOP_LAST)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sync_d     = {sync_q[0], rx};
    smp_d      = smp_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;

    if (sample_tick) begin
      smp_d = {smp_q[1:0], rx_s};
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          idx_d = '0;
          // A held-low line (break) must be seen high once before a new start counts.
          if (rx_s) armed_d = 1'b1;
        end
        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d      = '0;
            idx_d      = '0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
            armed_d    = rx_s;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (at_last) begin
            cnt_d          = '0;
            shift_d[idx_q] = vote;
            idx_d          = (idx_q == IDX_DATA_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (at_last) begin
            cnt_d = '0;
            if (PARITY == 1) perr_acc_d = ~(^{shift_q, vote});
            else             perr_acc_d = ^{shift_q, vote};
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (at_last) begin
            cnt_d = '0;
            if (!vote) ferr_acc_d = 1'b1;
            if (idx_q == IDX_STOP_LAST) begin
              idx_d   = '0;
              armed_d = rx_s;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_comb begin
    busy_d  = (state_d == ST_DATA) || (state_d == ST_PARITY) || (state_d == ST_STOP);
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    valid_d = valid_q;
    if (valid_q && rx_ready) valid_d = 1'b0;
    // A commit wins over a same-cycle accept; the overrun flag only reflects an unaccepted word.
    if (commit) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      perr_d  = perr_acc_q;
      ferr_d  = ferr_acc_q | ~vote;
      ovr_d   = valid_q & ~rx_ready;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = busy_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance (a) and an 8E2 instance (b) driven from serial
// waveforms built bit by bit, with words logged on handshake and compared to expectations.
module tb_uart_rx_os;

  localparam int OS      = 16;
  localparam int BIT_CLK = OS * 4;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } word_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic [1:0] stops;
    logic [7:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_tick = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic valid_a, busy_a, perr_a, ferr_a, ovr_a;
  logic valid_b, busy_b, perr_b, ferr_b, ovr_b;

  int n_checks = 0;
  int n_fail = 0;

  word_t log_a [64];
  word_t log_b [64];
  int wr_a = 0, wr_b = 0, rd_a = 0, rd_b = 0;
  int vcyc_a = 0, bcyc_a = 0;

  uart_rx_os #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx_a), .rx_ready(ready_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_busy(busy_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a)
  );

  uart_rx_os #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx_b), .rx_ready(ready_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_busy(busy_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (valid_a && ready_a && wr_a < 64) begin
      log_a[wr_a] = '{data_a, perr_a, ferr_a, ovr_a};
      wr_a++;
    end
    if (valid_b && ready_b && wr_b < 64) begin
      log_b[wr_b] = '{data_b, perr_b, ferr_b, ovr_b};
      wr_b++;
    end
    if (valid_a) vcyc_a++;
    if (busy_a) bcyc_a++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a frame's word follows directly from its bits -- data as sent, parity from the
  // count of ones, frame error if any stop bit is low, no overrun while the consumer is ready.
  function automatic word_t model_word(input logic [7:0] d, input int mode, input logic p,
                                       input logic [1:0] stops, input int ns);
    word_t w;
    int ones;
    ones   = $countones(d) + ((mode != 0) ? int'(p) : 0);
    w.data = d;
    w.perr = (mode == 1) ? (ones % 2 == 0) : (mode == 2) ? (ones % 2 == 1) : 1'b0;
    w.ferr = 1'b0;
    for (int i = 0; i < ns; i++) if (!stops[i]) w.ferr = 1'b1;
    w.ovr  = 1'b0;
    return w;
  endfunction

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic hold_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input int has_p, input logic p,
                            input logic [1:0] stops, input int ns);
    @(negedge clk);
    set_rx(which, 1'b0);
    hold_clks(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, d[i]);
      hold_clks(BIT_CLK);
    end
    if (has_p != 0) begin
      set_rx(which, p);
      hold_clks(BIT_CLK);
    end
    for (int i = 0; i < ns; i++) begin
      set_rx(which, stops[i]);
      hold_clks(BIT_CLK);
    end
  endtask

  task automatic idle_bits(input int which, input int n);
    set_rx(which, 1'b1);
    hold_clks(n * BIT_CLK);
  endtask

  task automatic expect_word(input string name, input int which, input word_t exp);
    word_t got;
    int avail;
    avail = (which == 0) ? wr_a - rd_a : wr_b - rd_b;
    if (avail < 1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no word received, want data 0x%02h", name, exp.data);
    end else begin
      if (which == 0) begin
        got = log_a[rd_a];
        rd_a++;
      end else begin
        got = log_b[rd_b];
        rd_b++;
      end
      $display("rx_%s %s: data=0x%02h perr=%0b ferr=%0b ovr=%0b", (which == 0) ? "a" : "b",
               name, got.data, got.perr, got.ferr, got.ovr);
      check({name, " data"}, 32'(got.data), 32'(exp.data));
      check({name, " perr"}, 32'(got.perr), 32'(exp.perr));
      check({name, " ferr"}, 32'(got.ferr), 32'(exp.ferr));
      check({name, " ovr"}, 32'(got.ovr), 32'(exp.ovr));
    end
  endtask

  task automatic expect_none(input string name, input int which);
    check({name, " pending words"}, 32'((which == 0) ? wr_a - rd_a : wr_b - rd_b), 32'd0);
  endtask

  vec_t tbl [8];

  initial begin
    int v0, b0, which, ns, mode;
    logic [7:0] d;
    logic p;
    logic [1:0] stops;

    tbl[0] = '{8'h5A, 1'b1, 2'b11, 8'h5A, 1'b1, 1'b0};
    tbl[1] = '{8'h5A, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0};
    tbl[2] = '{8'h01, 1'b1, 2'b11, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{8'h01, 1'b0, 2'b11, 8'h01, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 2'b01, 8'hFF, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 1'b1, 2'b10, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{8'hC3, 1'b1, 2'b00, 8'hC3, 1'b1, 1'b1};

    // Reset state
    hold_clks(3);
    check("reset a data", 32'(data_a), 32'd0);
    check("reset a valid", 32'(valid_a), 32'd0);
    check("reset a busy", 32'(busy_a), 32'd0);
    check("reset a flags", 32'({perr_a, ferr_a, ovr_a}), 32'd0);
    check("reset b valid", 32'(valid_b), 32'd0);
    check("reset b flags", 32'({perr_b, ferr_b, ovr_b}), 32'd0);
    rst_n = 1'b1;
    idle_bits(0, 2);

    // Clean 8N1 frame, consumer always ready: one-cycle valid pulse
    v0 = vcyc_a;
    send_frame(0, 8'hA5, 0, 1'b0, 2'b01, 1);
    idle_bits(0, 1);
    expect_word("clean A5", 0, '{8'hA5, 1'b0, 1'b0, 1'b0});
    check("clean A5 valid cycles", 32'(vcyc_a - v0), 32'd1);
    check("clean A5 busy idle", 32'(busy_a), 32'd0);

    // Even parity, two stop bits, table of frames
    idle_bits(1, 1);
    for (int i = 0; i < 8; i++) begin
      send_frame(1, tbl[i].d, 1, tbl[i].p, tbl[i].stops, 2);
      idle_bits(1, 2);
      expect_word($sformatf("tbl%0d", i), 1,
                  '{tbl[i].exp_d, tbl[i].exp_perr, tbl[i].exp_ferr, 1'b0});
    end
    expect_none("tbl end", 1);

    // Glitch: 5 ticks low is rejected at the start-bit centre
    b0 = bcyc_a;
    @(negedge clk);
    rx_a = 1'b0;
    hold_clks(5 * 4);
    idle_bits(0, 2);
    check("glitch busy cycles", 32'(bcyc_a - b0), 32'd0);
    expect_none("glitch", 0);
    send_frame(0, 8'h5C, 0, 1'b0, 2'b01, 1);
    idle_bits(0, 1);
    expect_word("after glitch 5C", 0, '{8'h5C, 1'b0, 1'b0, 1'b0});

    // Framing error followed by a held-low break
    send_frame(0, 8'h3C, 0, 1'b0, 2'b00, 1);
    expect_word("break 3C", 0, '{8'h3C, 1'b0, 1'b1, 1'b0});
    b0 = bcyc_a;
    hold_clks(3 * BIT_CLK);
    check("break busy cycles", 32'(bcyc_a - b0), 32'd0);
    expect_none("break hold", 0);
    idle_bits(0, 1);
    expect_none("break release", 0);
    send_frame(0, 8'h42, 0, 1'b0, 2'b01, 1);
    idle_bits(0, 1);
    expect_word("after break 42", 0, '{8'h42, 1'b0, 1'b0, 1'b0});

    // Overrun with consumer stalled, then accept
    @(posedge clk);
    #1 ready_a = 1'b0;
    send_frame(0, 8'h11, 0, 1'b0, 2'b01, 1);
    idle_bits(0, 1);
    check("ovr first valid", 32'(valid_a), 32'd1);
    check("ovr first data", 32'(data_a), 32'h11);
    check("ovr first flag", 32'(ovr_a), 32'd0);
    send_frame(0, 8'h22, 0, 1'b0, 2'b01, 1);
    idle_bits(0, 1);
    check("ovr second valid", 32'(valid_a), 32'd1);
    check("ovr second data", 32'(data_a), 32'h22);
    check("ovr second flag", 32'(ovr_a), 32'd1);
    check("ovr second other flags", 32'({perr_a, ferr_a}), 32'd0);
    @(posedge clk);
    #1 ready_a = 1'b1;
    @(negedge clk);
    check("accept valid before edge", 32'(valid_a), 32'd1);
    @(negedge clk);
    check("accept valid falls", 32'(valid_a), 32'd0);
    expect_word("ovr 22", 0, '{8'h22, 1'b0, 1'b0, 1'b1});

    // Asynchronous reset during data bit 4 of 0xFF
    @(negedge clk);
    rx_a = 1'b0;
    hold_clks(BIT_CLK);
    rx_a = 1'b1;
    hold_clks(4 * BIT_CLK + BIT_CLK / 2);
    check("midframe busy before reset", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midframe reset data", 32'(data_a), 32'd0);
    check("midframe reset valid", 32'(valid_a), 32'd0);
    check("midframe reset busy", 32'(busy_a), 32'd0);
    check("midframe reset flags", 32'({perr_a, ferr_a, ovr_a}), 32'd0);
    hold_clks(4);
    rst_n = 1'b1;
    idle_bits(0, 5);
    expect_none("midframe discarded", 0);
    send_frame(0, 8'h81, 0, 1'b0, 2'b01, 1);
    idle_bits(0, 2);
    check("after reset word count", 32'(wr_a - rd_a), 32'd1);
    expect_word("after reset 81", 0, '{8'h81, 1'b0, 1'b0, 1'b0});

    // Randomised frames on both instances against the reference model
    for (int k = 0; k < 12; k++) begin
      which = k % 2;
      ns    = (which == 0) ? 1 : 2;
      mode  = (which == 0) ? 0 : 2;
      d     = 8'($urandom);
      p     = 1'($urandom_range(0, 1));
      stops[0] = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      stops[1] = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      send_frame(which, d, (mode != 0) ? 1 : 0, p, stops, ns);
      idle_bits(which, 2);
      expect_word($sformatf("rand%0d", k), which, model_word(d, mode, p, stops, ns));
    end
    expect_none("rand end a", 0);
    expect_none("rand end b", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
